// File: rtl/id_exe_pipe_reg_if.sv
// ID/EXE boundary bundle: ID-side operands and control in, EXE-side registered copies out.
// The slave modport belongs to the pipeline register and the master modport to the surrounding pipeline.
interface id_exe_pipe_reg_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             suspend_i;
    logic             flush_i;
    logic             id_valid_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  rd1_i;
    logic [XLEN-1:0]  rd2_i;
    logic [XLEN-1:0]  imm_i;
    logic [4:0]       rR1_i;
    logic [4:0]       rR2_i;
    logic [4:0]       wr_i;
    logic             detect_r1_i;
    logic             detect_r2_i;
    logic             reg_we_i;
    logic             mem_we_i;
    logic             is_load_i;
    logic             is_sb_i;
    logic [3:0]       alu_op_i;
    logic [1:0]       wb_sel_i;
    logic             wb_we_i;
    logic [4:0]       wb_wr_i;
    logic [XLEN-1:0]  wb_data_i;

    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  rd1_o;
    logic [XLEN-1:0]  rd2_o;
    logic [XLEN-1:0]  imm_o;
    logic [4:0]       rR1_o;
    logic [4:0]       rR2_o;
    logic [4:0]       wr_o;
    logic             detect_r1_o;
    logic             detect_r2_o;
    logic             reg_we_o;
    logic             mem_we_o;
    logic             is_load_o;
    logic             is_sb_o;
    logic [3:0]       alu_op_o;
    logic [1:0]       wb_sel_o;
    logic             ex_valid_o;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  suspend_i, flush_i, id_valid_i, pc_i, rd1_i, rd2_i, imm_i,
               rR1_i, rR2_i, wr_i, detect_r1_i, detect_r2_i, reg_we_i,
               mem_we_i, is_load_i, is_sb_i, alu_op_i, wb_sel_i,
               wb_we_i, wb_wr_i, wb_data_i,
        output pc_o, rd1_o, rd2_o, imm_o, rR1_o, rR2_o, wr_o,
               detect_r1_o, detect_r2_o, reg_we_o, mem_we_o, is_load_o,
               is_sb_o, alu_op_o, wb_sel_o, ex_valid_o, stall_o, stall_cnt_o
    );

    modport master (
        output suspend_i, flush_i, id_valid_i, pc_i, rd1_i, rd2_i, imm_i,
               rR1_i, rR2_i, wr_i, detect_r1_i, detect_r2_i, reg_we_i,
               mem_we_i, is_load_i, is_sb_i, alu_op_i, wb_sel_i,
               wb_we_i, wb_wr_i, wb_data_i,
        input  pc_o, rd1_o, rd2_o, imm_o, rR1_o, rR2_o, wr_o,
               detect_r1_o, detect_r2_o, reg_we_o, mem_we_o, is_load_o,
               is_sb_o, alu_op_o, wb_sel_o, ex_valid_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with load-use hold, branch squash, WB write snooping
// and a saturating stall-cycle counter.
module id_exe_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    id_exe_pipe_reg_if.slave bus
);

    logic             stall;
    logic             snoop_ok;
    logic [XLEN-1:0]  cap_rd1;
    logic [XLEN-1:0]  cap_rd2;
    logic [XLEN-1:0]  hold_rd1;
    logic [XLEN-1:0]  hold_rd2;
    logic [CNT_W-1:0] cnt_q;

    // Capture snoops against the incoming source registers; hold snoops against the held ones.
    always_comb begin
        stall    = bus.suspend_i & ~bus.flush_i;
        snoop_ok = bus.wb_we_i & (bus.wb_wr_i != 5'd0);
        cap_rd1  = (snoop_ok && (bus.wb_wr_i == bus.rR1_i)) ? bus.wb_data_i : bus.rd1_i;
        cap_rd2  = (snoop_ok && (bus.wb_wr_i == bus.rR2_i)) ? bus.wb_data_i : bus.rd2_i;
        hold_rd1 = (snoop_ok && (bus.wb_wr_i == bus.rR1_o)) ? bus.wb_data_i : bus.rd1_o;
        hold_rd2 = (snoop_ok && (bus.wb_wr_i == bus.rR2_o)) ? bus.wb_data_i : bus.rd2_o;
    end

    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q           <= '0;
            bus.pc_o        <= '0;
            bus.rd1_o       <= '0;
            bus.rd2_o       <= '0;
            bus.imm_o       <= '0;
            bus.rR1_o       <= '0;
            bus.rR2_o       <= '0;
            bus.wr_o        <= '0;
            bus.detect_r1_o <= 1'b0;
            bus.detect_r2_o <= 1'b0;
            bus.reg_we_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.is_load_o   <= 1'b0;
            bus.is_sb_o     <= 1'b0;
            bus.alu_op_o    <= '0;
            bus.wb_sel_o    <= '0;
            bus.ex_valid_o  <= 1'b0;
        end else begin
            if (stall && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (bus.flush_i) begin
                // Datapath fields are left as-is; only what could cause a side effect is cleared.
                bus.ex_valid_o  <= 1'b0;
                bus.wr_o        <= '0;
                bus.detect_r1_o <= 1'b0;
                bus.detect_r2_o <= 1'b0;
                bus.reg_we_o    <= 1'b0;
                bus.mem_we_o    <= 1'b0;
                bus.is_load_o   <= 1'b0;
                bus.is_sb_o     <= 1'b0;
            end else if (bus.suspend_i) begin
                bus.rd1_o <= hold_rd1;
                bus.rd2_o <= hold_rd2;
            end else begin
                bus.pc_o        <= bus.pc_i;
                bus.rd1_o       <= cap_rd1;
                bus.rd2_o       <= cap_rd2;
                bus.imm_o       <= bus.imm_i;
                bus.rR1_o       <= bus.rR1_i;
                bus.rR2_o       <= bus.rR2_i;
                bus.alu_op_o    <= bus.alu_op_i;
                bus.wb_sel_o    <= bus.wb_sel_i;
                bus.ex_valid_o  <= bus.id_valid_i;
                bus.wr_o        <= bus.id_valid_i ? bus.wr_i : 5'd0;
                bus.detect_r1_o <= bus.id_valid_i & bus.detect_r1_i;
                bus.detect_r2_o <= bus.id_valid_i & bus.detect_r2_i;
                bus.reg_we_o    <= bus.id_valid_i & bus.reg_we_i;
                bus.mem_we_o    <= bus.id_valid_i & bus.mem_we_i;
                bus.is_load_o   <= bus.id_valid_i & bus.is_load_i;
                bus.is_sb_o     <= bus.id_valid_i & bus.is_sb_i;
            end
        end
    end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: expectations are queued as stimulus is driven and
// compared one cycle later against the registered EXE-side outputs.
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  wr;
        logic        ex_valid;
        logic        reg_we;
        logic        mem_we;
        logic [3:0]  cnt;
    } snap_t;

    typedef struct {
        string name;
        snap_t val;
        snap_t mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_cnt  = 0;
    exp_t        q[$];
    snap_t       m_all;
    snap_t       m_ctrl;
    snap_t       m_cnt;

    always #5 clk = ~clk;

    id_exe_pipe_reg_if #(.XLEN(32), .CNT_W(4)) bus ();

    id_exe_pipe_reg #(.XLEN(32), .CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic snap_t observe();
        snap_t s;
        s.pc       = bus.pc_o;
        s.rd1      = bus.rd1_o;
        s.rd2      = bus.rd2_o;
        s.wr       = bus.wr_o;
        s.ex_valid = bus.ex_valid_o;
        s.reg_we   = bus.reg_we_o;
        s.mem_we   = bus.mem_we_o;
        s.cnt      = bus.stall_cnt_o;
        return s;
    endfunction

    function automatic exp_t mk(input string name, input logic [31:0] pc, rd1, rd2,
                                input logic [4:0] wr, input logic v, we, mwe,
                                input int unsigned cnt, input snap_t mask);
        exp_t e;
        e.name         = name;
        e.val.pc       = pc;
        e.val.rd1      = rd1;
        e.val.rd2      = rd2;
        e.val.wr       = wr;
        e.val.ex_valid = v;
        e.val.reg_we   = we;
        e.val.mem_we   = mwe;
        e.val.cnt      = cnt[3:0];
        e.mask         = mask;
        return e;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned c);
        return (c >= 15) ? 15 : c + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic valid, input logic [31:0] pc, rd1, rd2,
                            input logic [4:0] r1, r2, wr, input logic reg_we, mem_we);
        bus.id_valid_i  = valid;
        bus.pc_i        = pc;
        bus.rd1_i       = rd1;
        bus.rd2_i       = rd2;
        bus.imm_i       = pc ^ 32'h0000_ffff;
        bus.rR1_i       = r1;
        bus.rR2_i       = r2;
        bus.wr_i        = wr;
        bus.reg_we_i    = reg_we;
        bus.mem_we_i    = mem_we;
        bus.detect_r1_i = 1'b0;
        bus.detect_r2_i = 1'b0;
        bus.is_load_i   = 1'b0;
        bus.is_sb_i     = 1'b0;
        bus.alu_op_i    = 4'h0;
        bus.wb_sel_i    = 2'b00;
    endtask

    task automatic test_reset();
        snap_t obs;
        rst = 1'b1;
        bus.suspend_i = 1'b0;
        bus.flush_i   = 1'b0;
        bus.wb_we_i   = 1'b0;
        bus.wb_wr_i   = 5'd0;
        bus.wb_data_i = 32'h0;
        drive_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_init: observed %h required %h", obs, snap_t'('0));
        end
        tick();
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_normal_flow();
        exp_t  e;
        snap_t obs;
        snap_t m_nowr;
        m_nowr    = m_ctrl;
        m_nowr.wr = '0;
        drive_id(1'b0, 32'h180, 32'h9, 32'h8, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        q.push_back(mk("bubble_load", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, exp_cnt, m_nowr));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        drive_id(1'b1, 32'h100, 32'h5, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        q.push_back(mk("normal_load", 32'h100, 32'h5, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
    endtask

    task automatic test_load_use_stall();
        exp_t  e;
        snap_t obs;
        bus.suspend_i = 1'b1;
        drive_id(1'b1, 32'h104, 32'h6, 32'h7, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus.stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_asserted[%0d]: observed %b required 1", i, bus.stall_o);
            end
            exp_cnt = sat_inc(exp_cnt);
            q.push_back(mk("stall_hold", 32'h100, 32'h5, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
            tick();
            e = q.pop_front(); obs = observe(); n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s[%0d]: observed %h required %h mask %h", e.name, i, obs, e.val, e.mask);
            end
        end
        bus.suspend_i = 1'b0;
        q.push_back(mk("stall_release", 32'h104, 32'h6, 32'h7, 5'd4, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
    endtask

    task automatic test_flush();
        exp_t  e;
        snap_t obs;
        bus.suspend_i = 1'b1;
        bus.flush_i   = 1'b1;
        drive_id(1'b1, 32'h108, 32'h8, 32'h9, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: observed %b required 0", bus.stall_o);
        end
        q.push_back(mk("flush_bubble", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, exp_cnt, m_ctrl));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        bus.suspend_i = 1'b0;
        bus.flush_i   = 1'b0;
    endtask

    task automatic test_wb_snoop();
        exp_t  e;
        snap_t obs;
        // capture with WB hitting rs1
        drive_id(1'b1, 32'h200, 32'h11, 32'h33, 5'd7, 5'd9, 5'd5, 1'b1, 1'b0);
        bus.wb_we_i = 1'b1; bus.wb_wr_i = 5'd7; bus.wb_data_i = 32'h22;
        q.push_back(mk("snoop_capture", 32'h200, 32'h22, 32'h33, 5'd5, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        // hold with WB hitting held rs2
        bus.suspend_i = 1'b1;
        drive_id(1'b1, 32'h204, 32'h44, 32'h55, 5'd7, 5'd9, 5'd5, 1'b1, 1'b0);
        bus.wb_wr_i = 5'd9; bus.wb_data_i = 32'hAB;
        exp_cnt = sat_inc(exp_cnt);
        q.push_back(mk("snoop_hold", 32'h200, 32'h22, 32'hAB, 5'd5, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        // hold with write enable low: no snoop
        bus.wb_we_i = 1'b0; bus.wb_wr_i = 5'd7; bus.wb_data_i = 32'h99;
        exp_cnt = sat_inc(exp_cnt);
        q.push_back(mk("snoop_hold_we0", 32'h200, 32'h22, 32'hAB, 5'd5, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        // register 0 on capture
        bus.suspend_i = 1'b0;
        drive_id(1'b1, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        bus.wb_we_i = 1'b1; bus.wb_wr_i = 5'd0; bus.wb_data_i = 32'h55;
        q.push_back(mk("snoop_r0_capture", 32'h300, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        // register 0 on hold
        bus.suspend_i = 1'b1;
        exp_cnt = sat_inc(exp_cnt);
        q.push_back(mk("snoop_r0_hold", 32'h300, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
        bus.suspend_i = 1'b0;
        bus.wb_we_i   = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t  e;
        snap_t obs;
        bus.suspend_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_cnt = sat_inc(exp_cnt);
            q.push_back(mk("cnt_sat", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, exp_cnt, m_cnt));
            tick();
            e = q.pop_front(); obs = observe(); n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s[%0d]: observed %h required %h mask %h", e.name, i, obs, e.val, e.mask);
            end
        end
        bus.suspend_i = 1'b0;
        q.push_back(mk("cnt_after_sat", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 15, m_cnt));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        snap_t       obs;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  w;
        logic        we;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h500 + 32'(4 * i);
            d1 = 32'(16 * i + 1);
            d2 = 32'hA000 + 32'(i);
            w  = 5'(i + 1);
            we = (i % 2) == 1;
            drive_id(1'b1, pc, d1, d2, 5'd10, 5'd11, w, we, ~we);
            q.push_back(mk("back_to_back", pc, d1, d2, w, 1'b1, we, ~we, exp_cnt, m_all));
            tick();
            e = q.pop_front(); obs = observe(); n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s[%0d]: observed %h required %h mask %h", e.name, i, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t  e;
        snap_t obs;
        bus.suspend_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: observed %h required %h", obs, snap_t'('0));
        end
        exp_cnt = 0;
        bus.suspend_i = 1'b0;
        #1 rst = 1'b1;
        drive_id(1'b1, 32'h400, 32'h77, 32'h88, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0);
        q.push_back(mk("load_after_reset", 32'h400, 32'h77, 32'h88, 5'd14, 1'b1, 1'b1, 1'b0, exp_cnt, m_all));
        tick();
        e = q.pop_front(); obs = observe(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h mask %h", e.name, obs, e.val, e.mask);
        end
    endtask

    initial begin
        m_all           = '1;
        m_ctrl          = '0;
        m_ctrl.wr       = '1;
        m_ctrl.ex_valid = 1'b1;
        m_ctrl.reg_we   = 1'b1;
        m_ctrl.mem_we   = 1'b1;
        m_ctrl.cnt      = '1;
        m_cnt           = '0;
        m_cnt.cnt       = '1;

        test_reset();
        test_normal_flow();
        test_load_use_stall();
        test_flush();
        test_wb_snoop();
        test_saturation();
        test_back_to_back();
        test_reset_midrun();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
